// File: rtl/sr_ff_driver.sv
// Command driver for an SR flip-flop: turns level requests into clean set/reset
// pulses, then watches the flip-flop output to confirm the level or time out.
module sr_ff_driver #(
    parameter int unsigned PULSE_W   = 1,
    parameter int unsigned TIMEOUT   = 4,
    parameter bit          SKIP_SAME = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req_valid,
    input  logic       req_level,
    output logic       req_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       level;
    logic       level_next;
    logic [3:0] pulse_cnt;
    logic [3:0] pulse_cnt_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       s_next;
    logic       r_next;
    logic       busy_next;
    logic       done_next;
    logic       err_next;
    logic [7:0] err_cnt_next;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            level     <= 1'b0;
            pulse_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
            s         <= 1'b0;
            r         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_next;
            level     <= level_next;
            pulse_cnt <= pulse_cnt_next;
            wait_cnt  <= wait_cnt_next;
            s         <= s_next;
            r         <= r_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
            err_cnt   <= err_cnt_next;
        end
    end

    // s and r are always derived from one latched level, so they can never overlap.
    always_comb begin
        state_next     = state;
        level_next     = level;
        pulse_cnt_next = pulse_cnt;
        wait_cnt_next  = wait_cnt;
        s_next         = s;
        r_next         = r;
        busy_next      = busy;
        done_next      = 1'b0;
        err_next       = 1'b0;
        err_cnt_next   = err_cnt;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    level_next = req_level;
                    if (SKIP_SAME && (q_fb == req_level)) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = PULSE;
                        s_next         = req_level;
                        r_next         = ~req_level;
                        pulse_cnt_next = PULSE_LOAD;
                        busy_next      = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (pulse_cnt == 4'd0) begin
                    s_next        = 1'b0;
                    r_next        = 1'b0;
                    state_next    = WAIT;
                    wait_cnt_next = 8'd0;
                end else begin
                    pulse_cnt_next = pulse_cnt - 4'd1;
                end
            end
            WAIT: begin
                s_next = 1'b0;
                r_next = 1'b0;
                if (q_fb == level) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                    if (err_cnt != 8'hFF) begin
                        err_cnt_next = err_cnt + 8'd1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                s_next     = 1'b0;
                r_next     = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
